// File: rtl/adder_ring_sequencer_if.sv
// rtl/adder_ring_sequencer_if.sv - control, config and result bundle between ring sequencer and adder/host
interface adder_ring_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int WIN_W = 16
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] cfg_a;
    logic [WIDTH-1:0] cfg_b;
    logic [WIDTH-1:0] cfg_ext_bit_b;
    logic [4:0]       cfg_bit;
    logic             cfg_sweep;
    logic [WIN_W-1:0] cfg_window;
    logic [31:0]      ring_count;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] ring_bit_b;
    logic [WIDTH-1:0] s_out_bit_b;
    logic [WIDTH-1:0] ext_bit_b;
    logic             ring_en;
    logic             count_clr;
    logic             busy;
    logic             result_valid;
    logic             result_ready;
    logic [31:0]      result_count;
    logic [4:0]       result_bit;
    logic             done;

    modport master (
        input  start, abort, cfg_a, cfg_b, cfg_ext_bit_b, cfg_bit, cfg_sweep, cfg_window,
               ring_count, result_ready,
        output add_a, add_b, ring_bit_b, s_out_bit_b, ext_bit_b, ring_en, count_clr,
               busy, result_valid, result_count, result_bit, done
    );

    modport slave (
        output start, abort, cfg_a, cfg_b, cfg_ext_bit_b, cfg_bit, cfg_sweep, cfg_window,
               ring_count, result_ready,
        input  add_a, add_b, ring_bit_b, s_out_bit_b, ext_bit_b, ring_en, count_clr,
               busy, result_valid, result_count, result_bit, done
    );
endinterface

// File: rtl/adder_ring_sequencer.sv
// rtl/adder_ring_sequencer.sv - clears, gates and samples the adder ring counter per bit
// Single-bit or sweep measurement; all outputs are registered.
module adder_ring_sequencer #(
    parameter int WIDTH         = 32,
    parameter int WIN_W         = 16,
    parameter int CLR_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    adder_ring_sequencer_if.master  bus
);
    localparam int BIT_W = $clog2(WIDTH);
    localparam int CNT_W = WIN_W + 1;
    localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(CLR_CYCLES);
    // One extra cycle past the settle time: ring_count is sampled on that edge
    // together with result_valid rising.
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES + 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_SETTLE,
        S_CAPTURE
    } state_t;

    state_t           r_state;
    logic [BIT_W-1:0] r_bit;
    logic             r_sweep;
    logic [CNT_W-1:0] r_window;
    logic [CNT_W-1:0] r_phase_cnt;
    logic [WIDTH-1:0] r_add_a;
    logic [WIDTH-1:0] r_add_b;
    logic [WIDTH-1:0] r_ext_bit_b;
    logic [WIDTH-1:0] r_ring_bit_b;
    logic [WIDTH-1:0] r_s_out_bit_b;
    logic             r_ring_en;
    logic             r_count_clr;
    logic             r_busy;
    logic             r_result_valid;
    logic [31:0]      r_result_count;
    logic [4:0]       r_result_bit;
    logic             r_done;

    logic [BIT_W-1:0] w_start_bit;
    logic [CNT_W-1:0] w_window_eff;

    function automatic logic [WIDTH-1:0] f_onehot(input logic [BIT_W-1:0] idx);
        return {{(WIDTH-1){1'b0}}, 1'b1} << idx;
    endfunction

    always_comb begin
        w_start_bit = '0;
        if (!bus.cfg_sweep) begin
            if (int'(bus.cfg_bit) >= WIDTH)
                w_start_bit = BIT_LAST;
            else
                w_start_bit = BIT_W'(bus.cfg_bit);
        end
    end

    // Window is widened by one bit so the maximum programmed window cannot wrap.
    assign w_window_eff = (bus.cfg_window == '0) ? CNT_W'(1) : {1'b0, bus.cfg_window};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state        <= S_IDLE;
            r_bit          <= '0;
            r_sweep        <= 1'b0;
            r_window       <= '0;
            r_phase_cnt    <= '0;
            r_add_a        <= '0;
            r_add_b        <= '0;
            r_ext_bit_b    <= '0;
            r_ring_bit_b   <= '0;
            r_s_out_bit_b  <= '0;
            r_ring_en      <= 1'b0;
            r_count_clr    <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_count <= '0;
            r_result_bit   <= '0;
            r_done         <= 1'b0;
        end else if (bus.abort) begin
            r_state        <= S_IDLE;
            r_phase_cnt    <= '0;
            r_ring_bit_b   <= '0;
            r_s_out_bit_b  <= '0;
            r_ring_en      <= 1'b0;
            r_count_clr    <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_bit         <= w_start_bit;
                        r_sweep       <= bus.cfg_sweep;
                        r_window      <= w_window_eff;
                        r_add_a       <= bus.cfg_a;
                        r_add_b       <= bus.cfg_b;
                        r_ext_bit_b   <= bus.cfg_ext_bit_b;
                        r_ring_bit_b  <= f_onehot(w_start_bit);
                        r_s_out_bit_b <= f_onehot(w_start_bit);
                        r_count_clr   <= 1'b1;
                        r_busy        <= 1'b1;
                        r_phase_cnt   <= CNT_W'(1);
                        r_state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_phase_cnt == CLR_LAST) begin
                        r_count_clr <= 1'b0;
                        r_ring_en   <= 1'b1;
                        r_phase_cnt <= CNT_W'(1);
                        r_state     <= S_RUN;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (r_phase_cnt == r_window) begin
                        r_ring_en   <= 1'b0;
                        r_phase_cnt <= CNT_W'(1);
                        r_state     <= S_SETTLE;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_phase_cnt == SETTLE_LAST) begin
                        r_result_count <= bus.ring_count;
                        r_result_bit   <= 5'(r_bit);
                        r_result_valid <= 1'b1;
                        r_phase_cnt    <= '0;
                        r_state        <= S_CAPTURE;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    if (bus.result_ready) begin
                        r_result_valid <= 1'b0;
                        if (r_sweep && (r_bit != BIT_LAST)) begin
                            r_bit         <= r_bit + BIT_W'(1);
                            r_ring_bit_b  <= f_onehot(r_bit + BIT_W'(1));
                            r_s_out_bit_b <= f_onehot(r_bit + BIT_W'(1));
                            r_count_clr   <= 1'b1;
                            r_phase_cnt   <= CNT_W'(1);
                            r_state       <= S_LOAD;
                        end else begin
                            r_ring_bit_b  <= '0;
                            r_s_out_bit_b <= '0;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                            r_state       <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.add_a        = r_add_a;
    assign bus.add_b        = r_add_b;
    assign bus.ext_bit_b    = r_ext_bit_b;
    assign bus.ring_bit_b   = r_ring_bit_b;
    assign bus.s_out_bit_b  = r_s_out_bit_b;
    assign bus.ring_en      = r_ring_en;
    assign bus.count_clr    = r_count_clr;
    assign bus.busy         = r_busy;
    assign bus.result_valid = r_result_valid;
    assign bus.result_count = r_result_count;
    assign bus.result_bit   = r_result_bit;
    assign bus.done         = r_done;
endmodule

// File: tb/tb_adder_ring_sequencer.sv
// tb/tb_adder_ring_sequencer.sv - self-checking bench for adder_ring_sequencer
module tb_adder_ring_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] r_ring_model;

    adder_ring_sequencer_if #(.WIDTH(32), .WIN_W(16)) bus ();

    adder_ring_sequencer #(
        .WIDTH(32), .WIN_W(16), .CLR_CYCLES(2), .SETTLE_CYCLES(4)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic int onehot_idx(input logic [31:0] v);
        for (int i = 0; i < 32; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    // Adder-side ring stand-in: counts faster for some operand/bit combinations.
    function automatic logic [31:0] step_of(input logic [31:0] a, input logic [31:0] b, input int bit_i);
        return 32'd1 + (((a ^ b) >> bit_i) & 32'd3);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst)
            r_ring_model <= '0;
        else if (bus.count_clr)
            r_ring_model <= '0;
        else if (bus.ring_en)
            r_ring_model <= r_ring_model + step_of(bus.add_a, bus.add_b, onehot_idx(bus.ring_bit_b));
    end
    assign bus.ring_count = r_ring_model;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ext,
                              input logic [4:0] bit_i, input logic [15:0] win, input bit inject,
                              output int clr_c, output int en_c, output int vedge,
                              output logic [31:0] ld_ring, output logic [31:0] ld_sout,
                              output logic [31:0] ld_a, output logic [31:0] ld_b,
                              output logic [31:0] ld_ext);
        int inj = 0;
        bus.cfg_a = a; bus.cfg_b = b; bus.cfg_ext_bit_b = ext;
        bus.cfg_bit = bit_i; bus.cfg_sweep = 1'b0; bus.cfg_window = win;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        clr_c = 0; en_c = 0; vedge = -1;
        ld_ring = bus.ring_bit_b; ld_sout = bus.s_out_bit_b;
        ld_a = bus.add_a; ld_b = bus.add_b; ld_ext = bus.ext_bit_b;
        for (int n = 0; n < 300; n++) begin
            if (bus.count_clr) clr_c++;
            if (bus.ring_en) en_c++;
            if (bus.result_valid) begin
                vedge = n;
                break;
            end
            if (inject) begin
                if (inj == 1) begin
                    bus.start = 1'b0;
                    inj = 2;
                end
                if (bus.ring_en && inj == 0) begin
                    bus.start = 1'b1; bus.cfg_bit = bit_i + 5'd1;
                    bus.cfg_a = ~a; bus.cfg_sweep = 1'b1; bus.cfg_window = 16'd9;
                    inj = 1;
                end
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic finish_single(input string tag);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(bus.result_valid), 64'(0));
        check({tag, "_done_pulse"}, 64'(bus.done), 64'(1));
        check({tag, "_busy_low"}, 64'(bus.busy), 64'(0));
        @(negedge clk);
        check({tag, "_done_single"}, 64'(bus.done), 64'(0));
    endtask

    initial begin
        int clr_c, en_c, vedge;
        logic [31:0] ld_ring, ld_sout, ld_a, ld_b, ld_ext;
        logic [31:0] a, b, ext;
        logic [4:0] bit_i;
        logic [15:0] win;
        logic [31:0] hold_cnt;
        logic [4:0] hold_bit;
        int nres, done_cnt, pending, bad;

        bus.start = 0; bus.abort = 0; bus.cfg_a = 0; bus.cfg_b = 0; bus.cfg_ext_bit_b = 0;
        bus.cfg_bit = 0; bus.cfg_sweep = 0; bus.cfg_window = 0; bus.result_ready = 0;
        repeat (3) @(negedge clk);
        check("rst_outputs", 64'({bus.add_a, bus.ring_bit_b}) | 64'({bus.add_b, bus.ext_bit_b})
              | 64'({bus.s_out_bit_b, bus.result_count}), 64'(0));
        check("rst_ctrl", 64'({bus.ring_en, bus.count_clr, bus.busy, bus.result_valid, bus.done, bus.result_bit}), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(bus.busy), 64'(0));

        // 1: single bit 10, window 8
        run_single(32'd0, 32'd0, 32'h0000_F00F, 5'd10, 16'd8, 1'b0, clr_c, en_c, vedge,
                   ld_ring, ld_sout, ld_a, ld_b, ld_ext);
        check("t1_ring_onehot", 64'(ld_ring), 64'h400);
        check("t1_sout_onehot", 64'(ld_sout), 64'h400);
        check("t1_ext", 64'(ld_ext), 64'h0000_F00F);
        check("t1_clr_cycles", 64'(clr_c), 64'(2));
        check("t1_en_cycles", 64'(en_c), 64'(8));
        check("t1_valid_edge", 64'(vedge), 64'(15));
        check("t1_bit", 64'(bus.result_bit), 64'(10));
        check("t1_count", 64'(bus.result_count), 64'(8));
        finish_single("t1");

        // random single measurements
        for (int k = 0; k < 3; k++) begin
            a = $urandom; b = $urandom; ext = $urandom;
            bit_i = 5'($urandom_range(0, 31)); win = 16'($urandom_range(1, 20));
            run_single(a, b, ext, bit_i, win, 1'b0, clr_c, en_c, vedge,
                       ld_ring, ld_sout, ld_a, ld_b, ld_ext);
            check("rs_operands", {ld_a, ld_b}, {a, b});
            check("rs_ring_onehot", 64'(ld_ring), 64'(32'd1 << bit_i));
            check("rs_en_cycles", 64'(en_c), 64'(win));
            check("rs_valid_edge", 64'(vedge), 64'(2 + int'(win) + 4 + 1));
            check("rs_bit", 64'(bus.result_bit), 64'(bit_i));
            check("rs_count", 64'(bus.result_count), 64'(32'(win) * step_of(a, b, int'(bit_i))));
            finish_single("rs");
        end

        // 2: sweep, window 4, ready high
        a = $urandom; b = $urandom;
        bus.cfg_a = a; bus.cfg_b = b; bus.cfg_sweep = 1'b1; bus.cfg_window = 16'd4;
        bus.cfg_bit = 5'd17; bus.result_ready = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nres = 0; done_cnt = 0; pending = 0;
        for (int n = 0; n < 1000; n++) begin
            if (pending != 0) begin
                check("sw_next_load_clr", 64'(bus.count_clr), 64'(1));
                check("sw_next_onehot", 64'(bus.ring_bit_b), 64'(32'd1 << nres));
                pending = 0;
            end
            if (bus.done) begin
                done_cnt++;
                check("sw_busy_after_done", 64'(bus.busy), 64'(0));
                break;
            end
            if (bus.result_valid) begin
                check("sw_bit", 64'(bus.result_bit), 64'(nres));
                check("sw_count", 64'(bus.result_count), 64'(32'd4 * step_of(a, b, nres)));
                if (nres < 31) pending = 1;
                nres++;
            end
            @(negedge clk);
        end
        check("sw_results", 64'(nres), 64'(32));
        check("sw_done_count", 64'(done_cnt), 64'(1));
        @(negedge clk);
        check("sw_done_once", 64'({bus.done, bus.busy}), 64'(0));
        bus.result_ready = 1'b0; bus.cfg_sweep = 1'b0;

        // 3: backpressure in CAPTURE
        a = $urandom; b = $urandom; bit_i = 5'($urandom_range(0, 31)); win = 16'($urandom_range(1, 12));
        run_single(a, b, 32'd0, bit_i, win, 1'b0, clr_c, en_c, vedge,
                   ld_ring, ld_sout, ld_a, ld_b, ld_ext);
        hold_cnt = bus.result_count; hold_bit = bus.result_bit;
        check("bp_count", 64'(hold_cnt), 64'(32'(win) * step_of(a, b, int'(bit_i))));
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.result_count !== hold_cnt || bus.result_bit !== hold_bit || bus.ring_en !== 1'b0
                || bus.count_clr !== 1'b0 || bus.result_valid !== 1'b1) bad++;
        end
        check("bp_stable_cycles_bad", 64'(bad), 64'(0));
        finish_single("bp");

        // 4: abort on the 3rd RUN cycle of 8
        bus.cfg_a = $urandom; bus.cfg_bit = 5'd3; bus.cfg_window = 16'd8; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        en_c = 0;
        for (int n = 0; n < 50 && en_c < 3; n++) begin
            if (bus.ring_en) en_c++;
            if (en_c < 3) @(negedge clk);
        end
        check("ab_reached_run", 64'(en_c), 64'(3));
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("ab_ring_en", 64'(bus.ring_en), 64'(0));
        check("ab_idle", 64'({bus.busy, bus.count_clr, bus.result_valid, bus.done}), 64'(0));
        check("ab_onehot_clear", 64'(bus.ring_bit_b), 64'(0));
        bad = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (bus.result_valid || bus.done || bus.ring_en || bus.busy) bad++;
        end
        check("ab_quiet_cycles_bad", 64'(bad), 64'(0));

        // 5: window 0 acts as 1; start during RUN ignored
        a = $urandom; b = $urandom;
        run_single(a, b, 32'd0, 5'd5, 16'd0, 1'b1, clr_c, en_c, vedge,
                   ld_ring, ld_sout, ld_a, ld_b, ld_ext);
        check("w0_en_cycles", 64'(en_c), 64'(1));
        check("w0_valid_edge", 64'(vedge), 64'(8));
        check("w0_bit", 64'(bus.result_bit), 64'(5));
        check("w0_count", 64'(bus.result_count), 64'(step_of(a, b, 5)));
        check("w0_operand_kept", 64'(bus.add_a), 64'(a));
        finish_single("w0");
        bad = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (bus.count_clr || bus.busy) bad++;
        end
        check("w0_no_relaunch_bad", 64'(bad), 64'(0));

        // 6: asynchronous reset during SETTLE
        bus.cfg_sweep = 1'b0;
        run_single(32'd0, 32'd0, 32'd0, 5'd0, 16'd0, 1'b0, clr_c, en_c, vedge,
                   ld_ring, ld_sout, ld_a, ld_b, ld_ext);
        finish_single("pre6");
        a = $urandom | 32'd1;
        bus.cfg_a = a; bus.cfg_b = $urandom; bus.cfg_ext_bit_b = 32'hFFFF_0000;
        bus.cfg_bit = 5'd20; bus.cfg_window = 16'd6; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        en_c = 0; bad = 1;
        for (int n = 0; n < 50; n++) begin
            if (bus.ring_en) en_c++;
            else if (en_c > 0) begin
                bad = 0;
                break;
            end
            @(negedge clk);
        end
        check("rs6_reached_settle", 64'(bad), 64'(0));
        check("rs6_pre_operand", 64'(bus.add_a), 64'(a));
        #2 rst = 1'b1;
        #1;
        check("rs6_operands_zero", 64'({bus.add_a, bus.add_b}), 64'(0));
        check("rs6_selects_zero", 64'(bus.ring_bit_b | bus.s_out_bit_b | bus.ext_bit_b), 64'(0));
        check("rs6_result_zero", 64'({bus.result_count, bus.result_bit}), 64'(0));
        check("rs6_ctrl_zero", 64'({bus.ring_en, bus.count_clr, bus.busy, bus.result_valid, bus.done}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rs6_idle_after", 64'(bus.busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
